ws2812_led_driver: RTL

Project-slot peripheral that drives a chain of WS2812 RGB LEDs from a single output pad. The harness forwards decoded Wishbone writes, as an LED index plus a 24-bit colour, into a local colour buffer. The block serialises that buffer onto the LED data line, with WS2812 bit timing, in repeating frames. It sits directly downstream of the multi-project harness: its `write` input is the harness's address-decoded write strobe, and its `data` output feeds one bit of the project's `io_out` bus.

---
 rtl/ws2812_led_driver.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ws2812_led_driver.sv
// WS2812 LED chain driver: a colour buffer written by the harness, serialised as {G,R,B} MSB-first frames.
// Optional WS2812_WRITE_TRIGGER_EN: send frames only after a buffer write instead of continuously.
module ws2812_led_driver #(
   parameter int NUM_LEDS = 8,
   parameter int T0H      = 14,
   parameter int T1H      = 28,
   parameter int T_BIT    = 50,
   parameter int T_LATCH  = 2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  led_num,
   input  logic [23:0] rgb_data,
   input  logic        write,
   output logic        data,
   output logic        busy
);

   localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int CW = $clog2(T_BIT);
   localparam int LW = (T_LATCH > 1) ? $clog2(T_LATCH) : 1;

   typedef enum logic [1:0] {LATCH, LOAD, SEND} state_t;

   state_t         state;
   logic [23:0]    led_buf [NUM_LEDS];
   logic [IW-1:0]  idx;
   logic [4:0]     bit_cnt;
   logic [CW-1:0]  cyc_cnt;
   logic [LW-1:0]  latch_cnt;
   logic [23:0]    shift;
   logic [23:0]    load_word;
   logic [CW-1:0]  cyc_next;
   logic [CW-1:0]  high_len;
   logic           accept;
   logic           go;

   assign accept    = write && ({1'b0, led_num} < 9'(NUM_LEDS));
   assign load_word = led_buf[idx];
   assign cyc_next  = cyc_cnt + CW'(1);
   assign high_len  = shift[23] ? CW'(T1H) : CW'(T0H);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_LEDS; i++) led_buf[i] <= '0;
      end else if (accept) begin
         led_buf[led_num[IW-1:0]] <= rgb_data;
      end
   end

`ifdef WS2812_WRITE_TRIGGER_EN
   logic dirty;

   // A write landing in the first LOAD cycle re-arms dirty, so it gets its own frame.
   always_ff @(posedge clk) begin
      if (reset) dirty <= 1'b0;
      else       dirty <= accept | (dirty & ~(state == LOAD && idx == '0));
   end

   assign go = dirty | accept;
`else
   assign go = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LATCH;
         idx       <= '0;
         bit_cnt   <= '0;
         cyc_cnt   <= '0;
         latch_cnt <= '0;
         shift     <= '0;
         data      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            LATCH: begin
               data <= 1'b0;
               // Counter saturates at expiry until a frame is allowed to start.
               if (latch_cnt == LW'(T_LATCH - 1)) begin
                  if (go) begin
                     state     <= LOAD;
                     idx       <= '0;
                     latch_cnt <= '0;
                     busy      <= 1'b1;
                  end
               end else begin
                  latch_cnt <= latch_cnt + LW'(1);
               end
            end
            LOAD: begin
               shift   <= {load_word[15:8], load_word[23:16], load_word[7:0]};
               bit_cnt <= 5'd23;
               cyc_cnt <= '0;
               data    <= 1'b1;
               state   <= SEND;
            end
            SEND: begin
               if (cyc_cnt == CW'(T_BIT - 1)) begin
                  cyc_cnt <= '0;
                  if (bit_cnt == 5'd0) begin
                     data <= 1'b0;
                     if (idx == IW'(NUM_LEDS - 1)) begin
                        state <= LATCH;
                        busy  <= 1'b0;
                     end else begin
                        idx   <= idx + IW'(1);
                        state <= LOAD;
                     end
                  end else begin
                     bit_cnt <= bit_cnt - 5'd1;
                     shift   <= {shift[22:0], 1'b0};
                     data    <= 1'b1;
                  end
               end else begin
                  cyc_cnt <= cyc_next;
                  data    <= (cyc_next < high_len);
               end
            end
            default: begin
               state <= LATCH;
               data  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
